// File: rtl/stat_reg_writer_if.sv
// Register-file access port: one write/read strobe pair, a 5-bit address
// and 16-bit write data. The same bundle describes the host bus feeding
// this block and the arbitrated port driving the 32x16 register file.
//   din  : write data
//   we   : write strobe
//   re   : read strobe
//   addr : register address
// Modports: master drives the bundle, slave receives it.
interface stat_reg_writer_if;
  logic [15:0] din;
  logic        we;
  logic        re;
  logic [4:0]  addr;

  modport master (output din, output we, output re, output addr);
  modport slave  (input din, input we, input re, input addr);
endinterface

// File: rtl/stat_reg_writer.sv
// Sample/spike statistics writer for the 32x16 host register file.
// Counts sample and spike pulses in saturating 32-bit counters. It takes a
// snapshot of both counters every UPDATE_PERIOD cycles and writes the
// snapshot as four 16-bit halves into fixed registers. The register-file
// port is shared with the host; host accesses always win.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   host (slave)        : host write data / strobes / address
//   smp_valid, spk_valid: one pulse per sample / per spike
//   cnt_clr             : synchronous clear of counters and overflow
//   eof                 : end-of-frame, freezes counting while high
//   mem (master)        : arbitrated register-file port
//   busy                : snapshot write sequence in progress
//   overflow            : sticky, a counter saturated
module stat_reg_writer #(
  parameter logic [4:0]  SMP_LO_ADDR   = 5'd4,
  parameter logic [4:0]  SMP_HI_ADDR   = 5'd5,
  parameter logic [4:0]  SPK_LO_ADDR   = 5'd6,
  parameter logic [4:0]  SPK_HI_ADDR   = 5'd7,
  parameter int unsigned UPDATE_PERIOD = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  stat_reg_writer_if.slave         host,
  input  logic                     smp_valid,
  input  logic                     spk_valid,
  input  logic                     cnt_clr,
  input  logic                     eof,
  stat_reg_writer_if.master        mem,
  output logic                     busy,
  output logic                     overflow
);

  localparam int          TW           = $clog2(UPDATE_PERIOD);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(UPDATE_PERIOD - 1);
  localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SMP_LO = 3'd1,
    WR_SMP_HI = 3'd2,
    WR_SPK_LO = 3'd3,
    WR_SPK_HI = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic          tick;
  logic          pending;
  logic          host_active;
  logic          start;
  logic          smp_inc;
  logic          spk_inc;
  logic          ovf_set;
  logic [31:0]   smp_cnt;
  logic [31:0]   spk_cnt;
  logic [31:0]   smp_nxt;
  logic [31:0]   spk_nxt;
  logic [31:0]   smp_snap;
  logic [31:0]   spk_snap;

  // Saturating counter step; clear beats a same-cycle increment.
  function automatic logic [31:0] cnt_next(input logic [31:0] cnt,
                                           input logic        inc,
                                           input logic        clr);
    logic [31:0] res;
    if (clr) begin
      res = 32'd0;
    end else if (inc && (cnt != CNT_MAX)) begin
      res = cnt + 32'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  assign host_active = host.we | host.re;
  assign tick        = (timer == '0);
  assign smp_inc     = smp_valid & ~eof;
  assign spk_inc     = spk_valid & ~eof;
  assign smp_nxt     = cnt_next(smp_cnt, smp_inc, cnt_clr);
  assign spk_nxt     = cnt_next(spk_cnt, spk_inc, cnt_clr);
  // Saturation is flagged on the increment that reaches (or sits at) the max.
  assign ovf_set     = (smp_inc && (smp_nxt == CNT_MAX)) ||
                       (spk_inc && (spk_nxt == CNT_MAX));
  // A tick seen while busy or while the host owns the port is deferred via
  // pending, so it is never lost and never queued more than once.
  assign start       = (state == IDLE) && !host_active && (tick || pending);
  assign busy        = (state != IDLE);

  // Snapshot timer: free-running down-counter, tick on reaching zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= TIMER_RELOAD;
    end else if (tick) begin
      timer <= TIMER_RELOAD;
    end else begin
      timer <= timer - TW'(1);
    end
  end

  // Live counters and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt  <= 32'd0;
      spk_cnt  <= 32'd0;
      overflow <= 1'b0;
    end else begin
      smp_cnt  <= smp_nxt;
      spk_cnt  <= spk_nxt;
      overflow <= cnt_clr ? 1'b0 : (overflow | ovf_set);
    end
  end

  // Snapshot capture (includes this cycle's increment) and deferred tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_snap <= 32'd0;
      spk_snap <= 32'd0;
      pending  <= 1'b0;
    end else begin
      if (start) begin
        smp_snap <= smp_nxt;
        spk_snap <= spk_nxt;
      end
      if (start) begin
        pending <= 1'b0;
      end else if (tick) begin
        pending <= 1'b1;
      end else begin
        pending <= pending;
      end
    end
  end

  // Write-sequence state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Port arbitration and next state: host passes straight through; the FSM
  // only drives the port, and only advances, when the host is idle.
  always_comb begin
    state_nxt = state;
    mem.we    = host.we;
    mem.re    = host.re;
    mem.addr  = host.addr;
    mem.din   = host.din;
    if (!host_active) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = WR_SMP_LO;
          end else begin
            state_nxt = IDLE;
          end
        end
        WR_SMP_LO: begin
          state_nxt = WR_SMP_HI;
          mem.we    = 1'b1;
          mem.re    = 1'b0;
          mem.addr  = SMP_LO_ADDR;
          mem.din   = smp_snap[15:0];
        end
        WR_SMP_HI: begin
          state_nxt = WR_SPK_LO;
          mem.we    = 1'b1;
          mem.re    = 1'b0;
          mem.addr  = SMP_HI_ADDR;
          mem.din   = smp_snap[31:16];
        end
        WR_SPK_LO: begin
          state_nxt = WR_SPK_HI;
          mem.we    = 1'b1;
          mem.re    = 1'b0;
          mem.addr  = SPK_LO_ADDR;
          mem.din   = spk_snap[15:0];
        end
        WR_SPK_HI: begin
          state_nxt = IDLE;
          mem.we    = 1'b1;
          mem.re    = 1'b0;
          mem.addr  = SPK_HI_ADDR;
          mem.din   = spk_snap[31:16];
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

endmodule

// File: tb/tb_stat_reg_writer.sv
// Directed bench for stat_reg_writer (UPDATE_PERIOD = 16). Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_stat_reg_writer;

  logic clk;
  logic rst;
  logic smp_valid;
  logic spk_valid;
  logic cnt_clr;
  logic eof;
  logic busy;
  logic overflow;
  int   total;
  int   bad;
  int   busy_len;

  stat_reg_writer_if host_bus ();
  stat_reg_writer_if mem_bus ();

  stat_reg_writer #(.UPDATE_PERIOD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host_bus),
    .smp_valid (smp_valid),
    .spk_valid (spk_valid),
    .cnt_clr   (cnt_clr),
    .eof       (eof),
    .mem       (mem_bus),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Compare {busy, we, re, addr, din} seen on the register-file port.
  task automatic exp_port(input string tag, input logic b, input logic we,
                          input logic [4:0] a, input logic [15:0] d);
    chk(tag, {8'h00, busy, mem_bus.we, mem_bus.re, mem_bus.addr, mem_bus.din},
             {8'h00, b, we, 1'b0, a, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n, input int n_spk);
    for (int i = 0; i < n; i++) begin
      smp_valid = 1'b1;
      spk_valid = (i < n_spk);
      step();
    end
    smp_valid = 1'b0;
    spk_valid = 1'b0;
  endtask

  // Wait for a fresh sequence: idle first, then the first busy cycle
  // (returns on that cycle's falling edge).
  task automatic wait_seq_start(input string tag);
    int n;
    n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    while (!busy && n < 128) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd1);
  endtask

  // Expect four uncontended snapshot writes starting at the current cycle.
  task automatic exp_seq(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3);
    exp_port({tag, "_lo"}, 1'b1, 1'b1, 5'd4, d0);
    @(negedge clk);
    exp_port({tag, "_hi"}, 1'b1, 1'b1, 5'd5, d1);
    @(negedge clk);
    exp_port({tag, "_slo"}, 1'b1, 1'b1, 5'd6, d2);
    @(negedge clk);
    exp_port({tag, "_shi"}, 1'b1, 1'b1, 5'd7, d3);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    smp_valid = 1'b0;
    spk_valid = 1'b0;
    cnt_clr = 1'b0;
    eof = 1'b0;
    host_bus.we = 1'b0;
    host_bus.re = 1'b0;
    host_bus.addr = 5'd3;
    host_bus.din = 16'h1234;

    // Reset: port follows the host, flags clear.
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_port("rst_idle", 1'b0, 1'b0, 5'd3, 16'h1234);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    host_bus.we = 1'b1;
    host_bus.re = 1'b1;
    #1;
    chk("rst_host_strobes", {30'd0, mem_bus.we, mem_bus.re}, 32'd3);
    host_bus.we = 1'b0;
    host_bus.re = 1'b0;
    step();
    rst = 1'b0;

    // 100 samples, 7 spikes, then the next snapshot writes 100,0,7,0.
    pulses(100, 7);
    wait_seq_start("t1_start");
    exp_seq("t1", 16'd100, 16'd0, 16'd7, 16'd0);
    @(negedge clk);
    chk("t1_done", {31'd0, busy}, 32'd0);

    // Host write held for 3 cycles in WR_SMP_HI stretches busy to 7.
    wait_seq_start("t2_start");
    exp_port("t2_lo", 1'b1, 1'b1, 5'd4, 16'd100);
    busy_len = 1;
    step();
    host_bus.we = 1'b1;
    host_bus.addr = 5'd9;
    host_bus.din = 16'hBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_port("t2_host", 1'b1, 1'b1, 5'd9, 16'hBEEF);
      busy_len += int'(busy);
      step();
    end
    host_bus.we = 1'b0;
    @(negedge clk);
    exp_port("t2_hi", 1'b1, 1'b1, 5'd5, 16'd0);
    busy_len += int'(busy);
    @(negedge clk);
    exp_port("t2_slo", 1'b1, 1'b1, 5'd6, 16'd7);
    busy_len += int'(busy);
    @(negedge clk);
    exp_port("t2_shi", 1'b1, 1'b1, 5'd7, 16'd0);
    busy_len += int'(busy);
    @(negedge clk);
    busy_len += int'(busy);
    chk("t2_busy_len", busy_len, 32'd7);

    // Saturation from FFFF_FFFE with 3 pulses.
    step();
    force dut.smp_cnt = 32'hFFFF_FFFE;
    step();
    release dut.smp_cnt;
    pulses(3, 0);
    @(negedge clk);
    chk("ovf_cnt", dut.smp_cnt, 32'hFFFF_FFFF);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    wait_seq_start("t3_start");
    exp_seq("t3", 16'hFFFF, 16'hFFFF, 16'd7, 16'd0);

    // Clear wins over a same-cycle pulse; overflow clears too.
    step();
    cnt_clr = 1'b1;
    smp_valid = 1'b1;
    spk_valid = 1'b1;
    step();
    cnt_clr = 1'b0;
    smp_valid = 1'b0;
    spk_valid = 1'b0;
    @(negedge clk);
    chk("clr_smp", dut.smp_cnt, 32'd0);
    chk("clr_spk", dut.spk_cnt, 32'd0);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);

    // eof freezes counting; dropping it resumes.
    step();
    eof = 1'b1;
    pulses(50, 50);
    @(negedge clk);
    chk("eof_frozen", dut.smp_cnt, 32'd0);
    step();
    eof = 1'b0;
    pulses(5, 2);
    @(negedge clk);
    chk("eof_resume", dut.smp_cnt, 32'd5);
    wait_seq_start("t4_start");
    exp_seq("t4", 16'd5, 16'd0, 16'd2, 16'd0);

    // Host holds the port 17 cycles across the next tick: one extra run.
    wait_seq_start("t6_start");
    exp_port("t6_lo", 1'b1, 1'b1, 5'd4, 16'd5);
    step();
    host_bus.we = 1'b1;
    host_bus.addr = 5'd10;
    host_bus.din = 16'h0A0A;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      exp_port("t6_host", 1'b1, 1'b1, 5'd10, 16'h0A0A);
      step();
    end
    host_bus.we = 1'b0;
    @(negedge clk);
    exp_port("t6_hi", 1'b1, 1'b1, 5'd5, 16'd0);
    @(negedge clk);
    exp_port("t6_slo", 1'b1, 1'b1, 5'd6, 16'd2);
    @(negedge clk);
    exp_port("t6_shi", 1'b1, 1'b1, 5'd7, 16'd0);
    @(negedge clk);
    chk("t6_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    exp_seq("t6_again", 16'd5, 16'd0, 16'd2, 16'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_third", {31'd0, busy}, 32'd0);
    end

    // Reset in the middle of a sequence.
    wait_seq_start("t7_start");
    step();
    rst = 1'b1;
    host_bus.addr = 5'd11;
    host_bus.din = 16'h1111;
    @(negedge clk);
    exp_port("rstmid_port", 1'b0, 1'b0, 5'd11, 16'h1111);
    chk("rstmid_smp", dut.smp_cnt, 32'd0);
    chk("rstmid_spk", dut.spk_cnt, 32'd0);
    host_bus.we = 1'b1;
    #1;
    chk("rstmid_host_we", {31'd0, mem_bus.we}, 32'd1);
    step();
    rst = 1'b0;
    host_bus.we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
